// File: rtl/div_seq_pkg.sv
// Shared encodings and handshake constants for the sequential divider.
package div_seq_pkg;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

   localparam int unsigned DOUBLE_REG_W = 64;
   typedef logic [DOUBLE_REG_W-1:0] double_reg_t;

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU: sequencer FSM plus one-bit-per-cycle datapath.
// Result packs {remainder, quotient} for HI/LO.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 stallreq_o
);

   localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
   localparam int unsigned WORK_W = 2 * WIDTH + 1;

   div_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [WORK_W-1:0]      work_q, work_d;
   logic [WIDTH-1:0]       divisor_q, divisor_d;
   logic                   neg_quo_q, neg_quo_d;
   logic                   neg_rem_q, neg_rem_d;
   logic [2*WIDTH-1:0]     result_q, result_d;
   logic                   ready_q, ready_d;

   logic [WIDTH-1:0]       op1_abs, op2_abs, quo, rem;
   logic [WIDTH:0]         trial;

   // Magnitudes for the unsigned core; the spare low bit of work_q pre-shifts the dividend.
   assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? WIDTH'(WIDTH'(0) - opdata1_i) : opdata1_i;
   assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? WIDTH'(WIDTH'(0) - opdata2_i) : opdata2_i;
   assign trial   = {1'b0, work_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};
   assign quo     = neg_quo_q ? WIDTH'(WIDTH'(0) - work_q[WIDTH-1:0]) : work_q[WIDTH-1:0];
   assign rem     = neg_rem_q ? WIDTH'(WIDTH'(0) - work_q[2*WIDTH:WIDTH+1]) : work_q[2*WIDTH:WIDTH+1];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      divisor_d = divisor_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      ready_d   = ready_q;

      case (state_q)
         DIV_FREE: begin
            result_d = '0;
            ready_d  = DIV_RESULT_NOT_READY;
            if (start_i == DIV_START && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_d = DIV_BYZERO;
               end else begin
                  state_d   = DIV_ON;
                  cnt_d     = '0;
                  divisor_d = op2_abs;
                  neg_quo_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                  neg_rem_d = signed_div_i & opdata1_i[WIDTH-1];
                  work_d    = {WIDTH'(0), op1_abs, 1'b0};
               end
            end
         end
         DIV_BYZERO: begin
            result_d = '0;
            if (annul_i) begin
               state_d = DIV_FREE;
               ready_d = DIV_RESULT_NOT_READY;
            end else begin
               state_d = DIV_END;
               ready_d = DIV_RESULT_READY;
            end
         end
         DIV_ON: begin
            if (annul_i) begin
               state_d  = DIV_FREE;
               result_d = '0;
               ready_d  = DIV_RESULT_NOT_READY;
               cnt_d    = '0;
            end else if (cnt_q != CNT_W'(WIDTH)) begin
               // Restore by simply not committing a negative trial.
               if (trial[WIDTH]) begin
                  work_d = {work_q[WORK_W-2:0], 1'b0};
               end else begin
                  work_d = {trial[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
               end
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               result_d = {rem, quo};
               ready_d  = DIV_RESULT_READY;
               state_d  = DIV_END;
               cnt_d    = '0;
            end
         end
         DIV_END: begin
            if (start_i == DIV_STOP || annul_i) begin
               state_d  = DIV_FREE;
               result_d = '0;
               ready_d  = DIV_RESULT_NOT_READY;
            end
         end
         default: state_d = DIV_FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DIV_FREE;
         cnt_q     <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         ready_q   <= DIV_RESULT_NOT_READY;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         divisor_q <= divisor_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
      end
   end

   assign result_o   = result_q;
   assign ready_o    = ready_q;
   assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule
